// File: rtl/mem_go_ctrl_pkg.sv
// Shared types for the memory stall/go controller: per-port state encoding and port limit.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    DROP
  } port_state_t;

  localparam int unsigned MAX_MEM_PORTS = 8;

endpackage

// File: rtl/mem_go_ctrl_if.sv
// Request/response bundle between the pipeline memory ports and mem_go_ctrl.
interface mem_go_ctrl_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req_i;
  logic [NUM_PORTS-1:0]        kill_i;
  logic [NUM_PORTS-1:0]        resp_i;
  logic [NUM_PORTS*DATA_W-1:0] rdata_i;
  logic                        go_o;
  logic [NUM_PORTS*DATA_W-1:0] rdata_o;
  logic [NUM_PORTS-1:0]        pending_o;
  logic                        busy_o;
  logic [31:0]                 stall_cnt_o;

  modport master (
    output req_i, kill_i, resp_i, rdata_i,
    input  go_o, rdata_o, pending_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  req_i, kill_i, resp_i, rdata_i,
    output go_o, rdata_o, pending_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/mem_go_ctrl_tracker.sv
// mem_port_tracker: one memory channel's IDLE/WAIT/DONE/DROP FSM plus its response data register.
import rv32i_types::*;

module mem_port_tracker #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              req,
  input  logic              kill,
  input  logic              resp,
  input  logic [DATA_W-1:0] rdata,
  output port_state_t       state,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
    end else begin
      case (state)
        IDLE: if (req) state <= WAIT;
        WAIT: begin
          if (kill) begin
            state <= resp ? IDLE : DROP;
          end else if (resp) begin
            state <= DONE;
            data  <= rdata;
          end
        end
        DONE: begin
          if (kill)    state <= IDLE;
          else if (go) state <= req ? WAIT : IDLE;
        end
        DROP: if (resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requester must wait for pending to clear before reissuing after a kill.
  always_ff @(posedge clk) begin
    if (!rst && state == DROP) assert (!req);
  end

endmodule

// File: rtl/mem_go_ctrl.sv
// Global pipeline go/stall unit over NUM_PORTS memory channels.
// Optional stall-cycle counter enabled by defining MEM_GO_STALL_CNT_EN.
import rv32i_types::*;

module mem_go_ctrl #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32
) (
  input logic         clk,
  input logic         rst,
  mem_go_ctrl_if.slave bus
);

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_MEM_PORTS) begin : g_bad_ports
    $error("mem_go_ctrl: NUM_PORTS out of range");
  end

  port_state_t                      state [NUM_PORTS];
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_q;
  logic [NUM_PORTS-1:0]             pending;
  logic                             go;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mem_port_tracker #(.DATA_W(DATA_W)) u_trk (
      .clk   (clk),
      .rst   (rst),
      .go    (go),
      .req   (bus.req_i[p]),
      .kill  (bus.kill_i[p]),
      .resp  (bus.resp_i[p]),
      .rdata (bus.rdata_i[p*DATA_W +: DATA_W]),
      .state (state[p]),
      .data  (data_q[p])
    );
  end

  // go is a pure decode of registered state, so resp/kill never reach it combinationally.
  always_comb begin
    pending = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pending[p] = (state[p] == WAIT) || (state[p] == DROP);
    end
  end

  assign go            = ~|pending;
  assign bus.go_o      = go;
  assign bus.pending_o = pending;
  assign bus.busy_o    = |pending;
  assign bus.rdata_o   = data_q;

`ifdef MEM_GO_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!go && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
`endif

endmodule
